// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory bus, with bounded
// lock for back-to-back transfers and a timeout that aborts stalled grants.
module mem_bus_arbiter #(
    parameter int TIMEOUT  = 255,
    parameter int MAX_LOCK = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_dataOut,
    input  logic [1:0]  m0_memType,
    input  logic        m0_lock,
    output logic [31:0] m0_dataIn,
    output logic        m0_ready,
    output logic        m0_err,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_dataOut,
    input  logic [1:0]  m1_memType,
    input  logic        m1_lock,
    output logic [31:0] m1_dataIn,
    output logic        m1_ready,
    output logic        m1_err,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_addr,
    output logic [31:0] s_dataOut,
    output logic [1:0]  s_memType,
    input  logic [31:0] s_dataIn,
    input  logic        s_ready,
    output logic [1:0]  grant
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t        state;
    logic          last;
    logic [TW-1:0] tcnt;
    logic [LW-1:0] lcnt;

    logic req0, req1, cur, cur_req, cur_lock;

    assign req0     = m0_read | m0_write;
    assign req1     = m1_read | m1_write;
    assign cur      = (state == GRANT1);
    assign cur_req  = cur ? req1 : req0;
    assign cur_lock = cur ? m1_lock : m0_lock;

    // Slave side and ready/data return are pure muxes so the bus adds no latency.
    always_comb begin
        s_read    = 1'b0;
        s_write   = 1'b0;
        s_addr    = '0;
        s_dataOut = '0;
        s_memType = '0;
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        m0_dataIn = '0;
        m1_dataIn = '0;
        case (state)
            GRANT0: begin
                s_read    = m0_read;
                s_write   = m0_write;
                s_addr    = m0_addr;
                s_dataOut = m0_dataOut;
                s_memType = m0_memType;
                m0_ready  = s_ready;
                m0_dataIn = s_dataIn;
            end
            GRANT1: begin
                s_read    = m1_read;
                s_write   = m1_write;
                s_addr    = m1_addr;
                s_dataOut = m1_dataOut;
                s_memType = m1_memType;
                m1_ready  = s_ready;
                m1_dataIn = s_dataIn;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state  <= IDLE;
            grant  <= 2'b00;
            last   <= 1'b1;
            tcnt   <= '0;
            lcnt   <= '0;
            m0_err <= 1'b0;
            m1_err <= 1'b0;
        end else begin
            m0_err <= 1'b0;
            m1_err <= 1'b0;
            case (state)
                IDLE: begin
                    // On a tie the master not granted last wins.
                    if (req0 && (!req1 || last)) begin
                        state <= GRANT0;
                        grant <= 2'b01;
                        tcnt  <= '0;
                    end else if (req1) begin
                        state <= GRANT1;
                        grant <= 2'b10;
                        tcnt  <= '0;
                    end
                end
                GRANT0, GRANT1: begin
                    if (s_ready) begin
                        tcnt <= '0;
                        if (cur_lock && (lcnt < LW'(MAX_LOCK - 1))) begin
                            lcnt <= lcnt + 1'b1;
                        end else begin
                            state <= IDLE;
                            grant <= 2'b00;
                            last  <= cur;
                            lcnt  <= '0;
                        end
                    end else if (!cur_req) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        last  <= cur;
                        lcnt  <= '0;
                        tcnt  <= '0;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        state  <= IDLE;
                        grant  <= 2'b00;
                        last   <= cur;
                        lcnt   <= '0;
                        tcnt   <= '0;
                        m0_err <= ~cur;
                        m1_err <= cur;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (TIMEOUT=8, MAX_LOCK=4).
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        res;
    logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
    logic [31:0] m0_addr, m0_dataOut, m1_addr, m1_dataOut;
    logic [1:0]  m0_memType, m1_memType;
    logic [31:0] m0_dataIn, m1_dataIn;
    logic        m0_ready, m0_err, m1_ready, m1_err;
    logic        s_read, s_write, s_ready;
    logic [31:0] s_addr, s_dataOut, s_dataIn;
    logic [1:0]  s_memType, grant;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.TIMEOUT(8), .MAX_LOCK(4)) dut (
        .clk(clk), .res(res),
        .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr),
        .m0_dataOut(m0_dataOut), .m0_memType(m0_memType), .m0_lock(m0_lock),
        .m0_dataIn(m0_dataIn), .m0_ready(m0_ready), .m0_err(m0_err),
        .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr),
        .m1_dataOut(m1_dataOut), .m1_memType(m1_memType), .m1_lock(m1_lock),
        .m1_dataIn(m1_dataIn), .m1_ready(m1_ready), .m1_err(m1_err),
        .s_read(s_read), .s_write(s_write), .s_addr(s_addr),
        .s_dataOut(s_dataOut), .s_memType(s_memType),
        .s_dataIn(s_dataIn), .s_ready(s_ready), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        res = 1'b0;
        {m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock} = '0;
        m0_addr = '0; m0_dataOut = '0; m0_memType = '0;
        m1_addr = '0; m1_dataOut = '0; m1_memType = '0;
        s_ready = 1'b0; s_dataIn = '0;
        @(posedge clk);
        @(posedge clk);
        #2;
        res = 1'b1;
        #1;
    endtask

    logic [1:0] exp_cont [7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    logic [1:0] exp_lock [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};

    initial begin
        do_reset();
        chk("rst_grant", grant, 2'b00);
        chk("rst_strobes", {s_read, s_write}, 2'b00);
        chk("rst_addr", s_addr, 32'h0);
        chk("rst_ready_err", {m0_ready, m1_ready, m0_err, m1_err}, 4'b0);
        chk("rst_dataIn", m0_dataIn | m1_dataIn, 32'h0);

        // s_ready while idle is not forwarded.
        s_ready = 1'b1; s_dataIn = 32'h1234_5678; #1;
        chk("idle_ready_ignored", {m0_ready, m1_ready}, 2'b00);
        chk("idle_dataIn", m0_dataIn, 32'h0);
        s_ready = 1'b0; s_dataIn = '0;

        // Single read, ready in the 2nd grant cycle.
        m0_read = 1'b1; m0_addr = 32'h100; m0_memType = 2'b01; #1;
        chk("single_pre_grant", grant, 2'b00);
        tick();
        chk("single_grant", grant, 2'b01);
        chk("single_s_read", s_read, 1'b1);
        chk("single_s_addr", s_addr, 32'h100);
        chk("single_memType", s_memType, 2'b01);
        chk("single_no_ready", m0_ready, 1'b0);
        tick();
        s_ready = 1'b1; s_dataIn = 32'hDEAD_BEEF; #1;
        chk("single_ready", m0_ready, 1'b1);
        chk("single_dataIn", m0_dataIn, 32'hDEAD_BEEF);
        chk("single_m1_ready", m1_ready, 1'b0);
        chk("single_m1_dataIn", m1_dataIn, 32'h0);
        tick();
        m0_read = 1'b0; s_ready = 1'b0; #1;
        chk("single_idle", grant, 2'b00);

        // Contention from reset with an always-ready slave.
        do_reset();
        m0_read = 1'b1; m1_read = 1'b1; s_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("cont_grant%0d", i), grant, exp_cont[i]);
            chk($sformatf("cont_ready%0d", i), {m1_ready, m0_ready}, exp_cont[i]);
        end

        // m1 locks, m0 waits until m1 has used its 4 back-to-back transfers.
        do_reset();
        m1_read = 1'b1; m1_lock = 1'b1; s_ready = 1'b1;
        tick();
        m0_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("lock_grant%0d", i), grant, exp_lock[i]);
            if (i < 4) chk($sformatf("lock_m1_ready%0d", i), m1_ready, 1'b1);
            tick();
        end

        // Timeout: grant held 8 cycles, then one err pulse.
        do_reset();
        m0_write = 1'b1; m0_dataOut = 32'h55AA_0001;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("to_grant%0d", i), grant, 2'b01);
            chk($sformatf("to_flags%0d", i), {m0_ready, m0_err}, 2'b00);
            tick();
        end
        chk("to_idle", grant, 2'b00);
        chk("to_err", m0_err, 1'b1);
        chk("to_m1_err", m1_err, 1'b0);
        m0_write = 1'b0;
        tick();
        chk("to_err_once", m0_err, 1'b0);
        chk("to_still_idle", grant, 2'b00);

        // m1 abandons its request in its 3rd grant cycle.
        do_reset();
        m1_read = 1'b1;
        tick();
        m0_read = 1'b1; #1;
        chk("abort_g1", grant, 2'b10);
        tick();
        chk("abort_g2", grant, 2'b10);
        tick();
        m1_read = 1'b0; #1;
        chk("abort_g3", grant, 2'b10);
        chk("abort_no_ready3", m1_ready, 1'b0);
        tick();
        chk("abort_idle", grant, 2'b00);
        chk("abort_flags", {m1_ready, m1_err}, 2'b00);
        tick();
        chk("abort_m0_next", grant, 2'b01);

        // Asynchronous reset during a GRANT1 write.
        do_reset();
        m1_write = 1'b1; m1_addr = 32'h200;
        tick();
        chk("ar_grant1", grant, 2'b10);
        chk("ar_s_write", s_write, 1'b1);
        #1 res = 1'b0;
        #1;
        chk("ar_s_write_drop", s_write, 1'b0);
        chk("ar_grant_drop", grant, 2'b00);
        chk("ar_addr_drop", s_addr, 32'h0);
        #1 res = 1'b1;
        m0_read = 1'b1;
        tick();
        chk("ar_tie_m0", grant, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
